// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read channel pair (AR/R) between the read arbiter and the AXI bridge.
// master: arbiter side (drives AR, rready); slave: bridge side (drives arready, R).
interface axi_rd_arbiter_if #(
   parameter int ID_W = 4
);
   logic [ID_W-1:0] arid;
   logic [31:0]     araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic            arvalid;
   logic            arready;
   logic [ID_W-1:0] rid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between icache and dcache; one transaction in
// flight, R beats steered to the owner, data reads held off while a dcache
// write is outstanding, sticky rd_err on any non-OKAY rresp.
// Ports: clk/reset (sync, active-high); inst_* and data_* cache read ports;
// wr_outstanding gates new data grants; axi = AXI AR/R master; rd_err.
// Option: ARB_ROUND_ROBIN_EN selects round-robin instead of data-first priority.
module axi_rd_arbiter #(
   parameter int ID_W    = 4,
   parameter int INST_ID = 0,
   parameter int DATA_ID = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inst_rd_req,
   input  logic [2:0]          inst_rd_type,
   input  logic [31:0]         inst_rd_addr,
   output logic                inst_rd_rdy,
   output logic                inst_ret_valid,
   output logic                inst_ret_last,
   output logic [31:0]         inst_ret_data,
   input  logic                data_rd_req,
   input  logic [2:0]          data_rd_type,
   input  logic [31:0]         data_rd_addr,
   output logic                data_rd_rdy,
   output logic                data_ret_valid,
   output logic                data_ret_last,
   output logic [31:0]         data_ret_data,
   input  logic                wr_outstanding,
   axi_rd_arbiter_if.master    axi,
   output logic                rd_err
);

   typedef enum logic [1:0] {IDLE, AR, R} state_t;

   state_t          state, state_nx;
   logic            own_data;
   logic [ID_W-1:0] arid_q;
   logic [31:0]     araddr_q;
   logic [7:0]      arlen_q;
   logic [2:0]      arsize_q;
   logic [1:0]      arburst_q;
   logic [1:0]      beat_cnt;
   logic            d_elig, i_elig;
   logic            gnt_d, gnt_i, grant;
   logic [2:0]      t_sel;
   logic            line;
   logic            beat;
`ifdef ARB_ROUND_ROBIN_EN
   // 1 = data wins the next contested grant
   logic            ptr;
`endif

   always_comb begin
      d_elig = data_rd_req && !wr_outstanding;
      i_elig = inst_rd_req;
`ifdef ARB_ROUND_ROBIN_EN
      gnt_d  = d_elig && (!i_elig || ptr);
`else
      gnt_d  = d_elig;
`endif
      gnt_i  = i_elig && !gnt_d;
      grant  = (state == IDLE) && (gnt_d || gnt_i);
      t_sel  = gnt_d ? data_rd_type : inst_rd_type;
      line   = (t_sel == 3'b100);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      inst_rd_rdy = 1'b0;
      data_rd_rdy = 1'b0;
      unique case (state)
         IDLE: begin
            inst_rd_rdy = gnt_i;
            data_rd_rdy = gnt_d;
            if (gnt_d || gnt_i) state_nx = AR;
         end
         AR: if (axi.arready) state_nx = R;
         R:  if (axi.rvalid && axi.rlast) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         own_data  <= 1'b0;
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
         beat_cnt  <= '0;
         rd_err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         ptr       <= 1'b0;
`endif
      end else begin
         if (grant) begin
            own_data  <= gnt_d;
            arid_q    <= gnt_d ? ID_W'(DATA_ID) : ID_W'(INST_ID);
            araddr_q  <= gnt_d ? data_rd_addr : inst_rd_addr;
            arlen_q   <= line ? 8'd3 : 8'd0;
            arsize_q  <= line ? 3'b010 : {1'b0, t_sel[1:0]};
            arburst_q <= 2'b01;
            beat_cnt  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr       <= gnt_i;
`endif
         end
         // Counter holds at arlen; overrun beats still go through until rlast.
         if (beat && beat_cnt != arlen_q[1:0])
            beat_cnt <= beat_cnt + 2'd1;
         if (beat && axi.rresp != 2'b00)
            rd_err <= 1'b1;
      end
   end

   always_comb begin
      beat           = (state == R) && axi.rvalid;
      inst_ret_valid = beat && !own_data;
      data_ret_valid = beat && own_data;
      inst_ret_last  = inst_ret_valid && axi.rlast;
      data_ret_last  = data_ret_valid && axi.rlast;
      inst_ret_data  = inst_ret_valid ? axi.rdata : '0;
      data_ret_data  = data_ret_valid ? axi.rdata : '0;
   end

   assign axi.arvalid = (state == AR);
   assign axi.rready  = (state == R);
   assign axi.arid    = arid_q;
   assign axi.araddr  = araddr_q;
   assign axi.arlen   = arlen_q;
   assign axi.arsize  = arsize_q;
   assign axi.arburst = arburst_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected R beats are queued when driven
// and checked when the arbiter forwards them to a cache port.
module tb_axi_rd_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_rd_req, data_rd_req, wr_outstanding;
   logic [2:0]  inst_rd_type, data_rd_type;
   logic [31:0] inst_rd_addr, data_rd_addr;
   logic        inst_rd_rdy, data_rd_rdy;
   logic        inst_ret_valid, inst_ret_last;
   logic        data_ret_valid, data_ret_last;
   logic [31:0] inst_ret_data, data_ret_data;
   logic        rd_err;

   int total = 0;
   int bad   = 0;
   bit ptr_m = 1'b0;
   bit err_m = 1'b0;

   typedef struct packed {
      logic        own;
      logic [31:0] d;
      logic        last;
   } beat_t;

   beat_t exp_q[$];

   always #5 clk = ~clk;

   axi_rd_arbiter_if #(.ID_W(4)) axi ();

   axi_rd_arbiter #(.ID_W(4), .INST_ID(0), .DATA_ID(1)) dut (
      .clk            (clk),
      .reset          (reset),
      .inst_rd_req    (inst_rd_req),
      .inst_rd_type   (inst_rd_type),
      .inst_rd_addr   (inst_rd_addr),
      .inst_rd_rdy    (inst_rd_rdy),
      .inst_ret_valid (inst_ret_valid),
      .inst_ret_last  (inst_ret_last),
      .inst_ret_data  (inst_ret_data),
      .data_rd_req    (data_rd_req),
      .data_rd_type   (data_rd_type),
      .data_rd_addr   (data_rd_addr),
      .data_rd_rdy    (data_rd_rdy),
      .data_ret_valid (data_ret_valid),
      .data_ret_last  (data_ret_last),
      .data_ret_data  (data_ret_data),
      .wr_outstanding (wr_outstanding),
      .axi            (axi),
      .rd_err         (rd_err)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      #3;
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (inst_ret_valid || data_ret_valid) begin
         if (exp_q.size() == 0) begin
            check("ret_unexpected", {inst_ret_valid, data_ret_valid}, 2'b00);
         end else begin
            e = exp_q.pop_front();
            check("ret_owner", {inst_ret_valid, data_ret_valid},
                  e.own ? 2'b01 : 2'b10);
            check("ret_data", e.own ? data_ret_data : inst_ret_data, e.d);
            check("ret_last", e.own ? data_ret_last : inst_ret_last, e.last);
         end
      end
   end

   task automatic idle_inputs();
      inst_rd_req    = 1'b0;
      data_rd_req    = 1'b0;
      inst_rd_type   = 3'b000;
      data_rd_type   = 3'b000;
      inst_rd_addr   = '0;
      data_rd_addr   = '0;
      wr_outstanding = 1'b0;
      axi.arready    = 1'b0;
      axi.rid        = '0;
      axi.rdata      = '0;
      axi.rresp      = 2'b00;
      axi.rlast      = 1'b0;
      axi.rvalid     = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_arvalid"}, axi.arvalid, 1'b0);
      check({tag, "_rready"}, axi.rready, 1'b0);
      check({tag, "_ret_v"}, {inst_ret_valid, data_ret_valid}, 2'b00);
      check({tag, "_ar_flds"},
            {axi.araddr, axi.arid, axi.arlen, axi.arsize, axi.arburst}, '0);
      check({tag, "_rd_err"}, rd_err, 1'b0);
   endtask

   // ir/dr: who requests; wr_hold: cycles with wr_outstanding high first;
   // err_beat: beat with SLVERR; abort_at: beat index where reset hits.
   task automatic txn(input bit ir, input bit dr, input logic [31:0] a,
                      input logic [2:0] t, input int wr_hold,
                      input int ar_dly, input int err_beat,
                      input int abort_at);
      bit          wd;
      bit          line;
      int          nb;
      logic [31:0] d;
`ifdef ARB_ROUND_ROBIN_EN
      wd = dr && (!ir || ptr_m);
`else
      wd = dr;
`endif
      line = (t == 3'b100);
      nb   = line ? 4 : 1;
      inst_rd_req  = ir;
      data_rd_req  = dr;
      inst_rd_addr = a;
      data_rd_addr = a;
      inst_rd_type = t;
      data_rd_type = t;
      for (int i = 0; i < wr_hold; i++) begin
         wr_outstanding = 1'b1;
         samp();
         check("wr_gate_d", data_rd_rdy, 1'b0);
         check("wr_gate_i", inst_rd_rdy, 1'b0);
         cyc();
      end
      wr_outstanding = 1'b0;
      samp();
      check("rdy_d", data_rd_rdy, wd);
      check("rdy_i", inst_rd_rdy, !wd);
      ptr_m = !wd;
      cyc();
      inst_rd_req  = 1'b0;
      data_rd_req  = 1'b0;
      inst_rd_addr = 32'hDEAD_BEEF;
      data_rd_addr = 32'hDEAD_BEEF;
      samp();
      check("ar_valid", axi.arvalid, 1'b1);
      check("ar_id", axi.arid, wd ? 4'd1 : 4'd0);
      check("ar_addr", axi.araddr, a);
      check("ar_len", axi.arlen, line ? 8'd3 : 8'd0);
      check("ar_size", axi.arsize, line ? 3'b010 : {1'b0, t[1:0]});
      check("ar_burst", axi.arburst, 2'b01);
      for (int k = 0; k < ar_dly; k++) begin
         cyc();
         samp();
         check("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, a});
      end
      cyc();
      axi.arready = 1'b1;
      samp();
      check("ar_hs", axi.arvalid, 1'b1);
      cyc();
      axi.arready = 1'b0;
      samp();
      check("ar_drop", axi.arvalid, 1'b0);
      check("r_ready", axi.rready, 1'b1);
      for (int i = 0; i < nb; i++) begin
         cyc();
         if (i == abort_at) begin
            reset      = 1'b1;
            axi.rvalid = 1'b0;
            cyc();
            samp();
            check("abort_rready", axi.rready, 1'b0);
            check("abort_arvalid", axi.arvalid, 1'b0);
            for (int j = i; j < nb; j++) begin
               cyc();
               axi.rvalid = 1'b1;
               axi.rdata  = $urandom;
               axi.rlast  = (j == nb - 1);
            end
            cyc();
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            reset      = 1'b0;
            ptr_m      = 1'b0;
            err_m      = 1'b0;
            samp();
            check_quiet("post_abort");
            return;
         end
         d = $urandom;
         axi.rvalid = 1'b1;
         axi.rdata  = d;
         axi.rlast  = (i == nb - 1);
         axi.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
         axi.rid    = wd ? 4'd1 : 4'd0;
         if (i == err_beat) err_m = 1'b1;
         exp_q.push_back('{own: wd, d: d, last: (i == nb - 1)});
      end
      cyc();
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rresp  = 2'b00;
      samp();
      check("end_rready", axi.rready, 1'b0);
      check("end_arvalid", axi.arvalid, 1'b0);
      check("rd_err", rd_err, err_m);
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      cyc();
      cyc();
      samp();
      check_quiet("reset");
      check("reset_rdy", {inst_rd_rdy, data_rd_rdy}, 2'b00);
      reset = 1'b0;
      cyc();
      samp();
      check_quiet("idle");

      txn(1'b1, 1'b0, 32'h1C00_0040, 3'b100, 0, 2, -1, -1);
      txn(1'b0, 1'b1, 32'hBFAF_8001, 3'b000, 0, 0, -1, -1);
      txn(1'b0, 1'b1, 32'h0000_0102, 3'b001, 0, 1, -1, -1);

      for (int n = 0; n < 4; n++)
         txn(1'b1, 1'b1, 32'h0000_0400 + 32'(n * 4), 3'b010, 0, 0, -1, -1);

      txn(1'b0, 1'b1, 32'h0000_1000, 3'b010, 5, 0, -1, -1);

      txn(1'b0, 1'b1, 32'h0000_2000, 3'b100, 0, 1, 1, -1);
      txn(1'b1, 1'b0, 32'h1C00_0010, 3'b010, 0, 0, -1, -1);

      txn(1'b1, 1'b0, 32'h1C00_0080, 3'b100, 0, 0, -1, 2);
      txn(1'b1, 1'b0, 32'h1C00_00C0, 3'b100, 0, 1, -1, -1);

      cyc();
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
